// File: rtl/ofs_plat_host_chan_merge_tx_tlps.sv
// Merges a sideband header stream and a bit-0-aligned payload stream into one TLP stream.
// The header goes in-band at tdata[0]. Payload is shifted up by HDR_WIDTH, so any overflow spills into the next beat.
module ofs_plat_host_chan_merge_tx_tlps #(
    parameter int TDATA_WIDTH = 512,
    parameter int HDR_WIDTH   = 256
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     i_hdr_tvalid,
    output logic                     o_hdr_tready,
    input  logic [HDR_WIDTH-1:0]     i_hdr_tdata,
    input  logic                     i_hdr_dm_mode,
    input  logic                     i_hdr_has_data,

    input  logic                     i_data_tvalid,
    output logic                     o_data_tready,
    input  logic [TDATA_WIDTH-1:0]   i_data_tdata,
    input  logic [TDATA_WIDTH/8-1:0] i_data_tkeep,
    input  logic                     i_data_tlast,

    output logic                     o_out_tvalid,
    input  logic                     i_out_tready,
    output logic [TDATA_WIDTH-1:0]   o_out_tdata,
    output logic [TDATA_WIDTH/8-1:0] o_out_tkeep,
    output logic                     o_out_tlast,
    output logic                     o_out_sop,
    output logic                     o_out_dm_mode
);

    localparam int KW     = TDATA_WIDTH / 8;
    localparam int DAH_W  = TDATA_WIDTH - HDR_WIDTH;
    localparam int HDR_KW = HDR_WIDTH / 8;
    localparam int DAH_KW = DAH_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // Only the upper HDR_WIDTH of the last payload beat ever spills into the next beat.
    logic [HDR_WIDTH-1:0]   r_prev_hi;
    logic [HDR_KW-1:0]      r_prev_khi;
    logic                   r_dm_mode;

    logic                   r_out_tvalid;
    logic [TDATA_WIDTH-1:0] r_out_tdata;
    logic [KW-1:0]          r_out_tkeep;
    logic                   r_out_tlast;
    logic                   r_out_sop;
    logic                   r_out_dm_mode;

    logic                   w_adv;
    logic                   w_ovf;
    logic                   w_in_idle;
    logic                   w_in_body;
    logic                   w_hdr_rdy;
    logic                   w_data_rdy;
    logic                   w_hdr_pop;
    logic                   w_data_pop;

    logic                   w_emit;
    logic [TDATA_WIDTH-1:0] w_beat_dat;
    logic [KW-1:0]          w_beat_keep;
    logic                   w_beat_last;
    logic                   w_beat_sop;
    logic                   w_beat_dm;

    assign w_adv     = !r_out_tvalid || i_out_tready;
    assign w_ovf     = i_data_tkeep[DAH_KW];
    assign w_in_idle = (r_state == ST_IDLE);
    assign w_in_body = (r_state == ST_BODY);

    // A header that carries payload is popped only together with its first data beat.
    assign w_hdr_rdy  = reset_n && w_in_idle && w_adv && (!i_hdr_has_data || i_data_tvalid);
    assign w_data_rdy = reset_n && w_adv &&
                        ((w_in_idle && i_hdr_tvalid && i_hdr_has_data) || w_in_body);
    assign w_hdr_pop  = w_hdr_rdy && i_hdr_tvalid;
    assign w_data_pop = w_data_rdy && i_data_tvalid;

    assign o_hdr_tready  = w_hdr_rdy;
    assign o_data_tready = w_data_rdy;

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_beat_dat  = '0;
        w_beat_keep = '0;
        w_beat_last = 1'b0;
        w_beat_sop  = 1'b0;
        w_beat_dm   = r_dm_mode;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_pop) begin
                    w_emit     = 1'b1;
                    w_beat_sop = 1'b1;
                    w_beat_dm  = i_hdr_dm_mode;
                    if (!i_hdr_has_data) begin
                        w_beat_dat  = {{DAH_W{1'b0}}, i_hdr_tdata};
                        w_beat_keep = {{DAH_KW{1'b0}}, {HDR_KW{1'b1}}};
                        w_beat_last = 1'b1;
                    end else begin
                        w_beat_dat  = {i_data_tdata[DAH_W-1:0], i_hdr_tdata};
                        w_beat_keep = {i_data_tkeep[DAH_KW-1:0], {HDR_KW{1'b1}}};
                        if (i_data_tlast && !w_ovf) begin
                            w_beat_last = 1'b1;
                        end else if (i_data_tlast) begin
                            w_state_nxt = ST_DRAIN;
                        end else begin
                            w_state_nxt = ST_BODY;
                        end
                    end
                end
            end
            ST_BODY: begin
                if (w_data_pop) begin
                    w_emit      = 1'b1;
                    w_beat_dat  = {i_data_tdata[DAH_W-1:0], r_prev_hi};
                    w_beat_keep = {i_data_tkeep[DAH_KW-1:0], r_prev_khi};
                    if (i_data_tlast && !w_ovf) begin
                        w_beat_last = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (i_data_tlast) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_adv) begin
                    w_emit      = 1'b1;
                    w_beat_dat  = {{DAH_W{1'b0}}, r_prev_hi};
                    w_beat_keep = {{DAH_KW{1'b0}}, r_prev_khi};
                    w_beat_last = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_prev_hi     <= '0;
            r_prev_khi    <= '0;
            r_dm_mode     <= 1'b0;
            r_out_tvalid  <= 1'b0;
            r_out_tdata   <= '0;
            r_out_tkeep   <= '0;
            r_out_tlast   <= 1'b0;
            r_out_sop     <= 1'b0;
            r_out_dm_mode <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hdr_pop) begin
                r_dm_mode <= i_hdr_dm_mode;
            end
            if (w_data_pop) begin
                r_prev_hi  <= i_data_tdata[TDATA_WIDTH-1:DAH_W];
                r_prev_khi <= i_data_tkeep[KW-1:DAH_KW];
            end
            if (w_adv) begin
                r_out_tvalid <= w_emit;
                if (w_emit) begin
                    r_out_tdata   <= w_beat_dat;
                    r_out_tkeep   <= w_beat_keep;
                    r_out_tlast   <= w_beat_last;
                    r_out_sop     <= w_beat_sop;
                    r_out_dm_mode <= w_beat_dm;
                end
            end
        end
    end

    assign o_out_tvalid  = r_out_tvalid;
    assign o_out_tdata   = r_out_tdata;
    assign o_out_tkeep   = r_out_tkeep;
    assign o_out_tlast   = r_out_tlast;
    assign o_out_sop     = r_out_sop;
    assign o_out_dm_mode = r_out_dm_mode;

endmodule
